exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_pkg.sv | 30 +++
 rtl/exec_sequencer_if.sv | 32 +++
 rtl/exec_alu.sv | 48 ++++
 rtl/exec_sequencer.sv | 109 ++++++++++
 tb/tb_exec_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared types and widths for the three-operand execute sequencer.
package exec_pkg;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned REG_AW    = 3;
    localparam int unsigned STATUS_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ_A = 3'd1,
        S_READ_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MVN = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_t;

endpackage

// File: rtl/exec_sequencer_if.sv
// Request handshake, register-file port and result signals of the sequencer.
interface exec_sequencer_if;
    import exec_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [1:0]            req_shift;
    logic [REG_AW-1:0]     req_rn;
    logic [REG_AW-1:0]     req_rm;
    logic [REG_AW-1:0]     req_rd;
    logic                  req_wb;
    logic [REG_AW-1:0]     rf_readnum;
    logic [WIDTH-1:0]      rf_data_out;
    logic [REG_AW-1:0]     rf_writenum;
    logic                  rf_write;
    logic [WIDTH-1:0]      rf_data_in;
    logic [WIDTH-1:0]      result;
    logic [STATUS_W-1:0]   status;
    logic                  done;

    modport slave (
        input  req_valid, req_op, req_shift, req_rn, req_rm, req_rd, req_wb, rf_data_out,
        output req_ready, rf_readnum, rf_writenum, rf_write, rf_data_in, result, status, done
    );

    modport master (
        output req_valid, req_op, req_shift, req_rn, req_rm, req_rd, req_wb, rf_data_out,
        input  req_ready, rf_readnum, rf_writenum, rf_write, rf_data_in, result, status, done
    );

endinterface

// File: rtl/exec_alu.sv
// Combinational one-bit shifter on B, 4-op ALU and {Z,N,V} flag generation.
module exec_alu
    import exec_pkg::*;
(
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_b,
    input  op_t                 i_op,
    input  shift_t              i_shift,
    output logic [WIDTH-1:0]    o_value,
    output logic [STATUS_W-1:0] o_status
);

    logic [WIDTH-1:0] w_bsh;
    logic [WIDTH-1:0] w_val;
    logic             w_v;

    always_comb begin
        w_bsh = i_b;
        case (i_shift)
            SH_LSL:  w_bsh = {i_b[WIDTH-2:0], 1'b0};
            SH_LSR:  w_bsh = {1'b0, i_b[WIDTH-1:1]};
            SH_ASR:  w_bsh = {i_b[WIDTH-1], i_b[WIDTH-1:1]};
            default: w_bsh = i_b;
        endcase
    end

    // Overflow: operands of like sign (after negating B for SUB) giving a result of the other sign.
    always_comb begin
        w_val = '0;
        w_v   = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_val = i_a + w_bsh;
                w_v   = (i_a[WIDTH-1] == w_bsh[WIDTH-1]) && (w_val[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_val = i_a - w_bsh;
                w_v   = (i_a[WIDTH-1] != w_bsh[WIDTH-1]) && (w_val[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  w_val = i_a & w_bsh;
            default: w_val = ~w_bsh;
        endcase
    end

    assign o_value  = w_val;
    assign o_status = {(w_val == '0), w_val[WIDTH-1], w_v};

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle read-A / read-B / execute / write-back sequencer around a shared register file.
module exec_sequencer
    import exec_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    exec_sequencer_if.slave  bus
);

    state_t              r_state;
    op_t                 r_op;
    shift_t              r_shift;
    logic [REG_AW-1:0]   r_rm;
    logic [REG_AW-1:0]   r_rd;
    logic                r_wb;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_c;
    logic [STATUS_W-1:0] r_status;
    logic                r_ready;
    logic [REG_AW-1:0]   r_readnum;
    logic [REG_AW-1:0]   r_writenum;
    logic                r_write;
    logic                r_done;

    logic [WIDTH-1:0]    w_value;
    logic [STATUS_W-1:0] w_status;

    exec_alu u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .i_shift  (r_shift),
        .o_value  (w_value),
        .o_status (w_status)
    );

    // Outputs are loaded one state ahead so they are valid for the whole state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= OP_ADD;
            r_shift    <= SH_NONE;
            r_rm       <= '0;
            r_rd       <= '0;
            r_wb       <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_status   <= '0;
            r_ready    <= 1'b1;
            r_readnum  <= '0;
            r_writenum <= '0;
            r_write    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op      <= op_t'(bus.req_op);
                        r_shift   <= shift_t'(bus.req_shift);
                        r_rm      <= bus.req_rm;
                        r_rd      <= bus.req_rd;
                        r_wb      <= bus.req_wb;
                        r_readnum <= bus.req_rn;
                        r_ready   <= 1'b0;
                        r_state   <= S_READ_A;
                    end
                end
                S_READ_A: begin
                    r_a       <= bus.rf_data_out;
                    r_readnum <= r_rm;
                    r_state   <= S_READ_B;
                end
                S_READ_B: begin
                    r_b       <= bus.rf_data_out;
                    r_readnum <= '0;
                    r_state   <= S_EXEC;
                end
                S_EXEC: begin
                    r_c        <= w_value;
                    r_status   <= w_status;
                    r_writenum <= r_rd;
                    r_write    <= r_wb;
                    r_done     <= 1'b1;
                    r_state    <= S_WB;
                end
                S_WB: begin
                    r_write <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Reset on the write-back edge must suppress the write and the completion pulse.
    assign bus.rf_write    = r_write && !reset;
    assign bus.done        = r_done && !reset;
    assign bus.req_ready   = r_ready;
    assign bus.rf_readnum  = r_readnum;
    assign bus.rf_writenum = r_writenum;
    assign bus.rf_data_in  = r_c;
    assign bus.result      = r_c;
    assign bus.status      = r_status;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench: sequencer attached to an 8x16 register file model.
module tb_exec_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic        tb_ld;
    logic [2:0]  tb_addr;
    logic [15:0] tb_data;
    logic [15:0] rf [8];

    exec_sequencer_if bus ();

    exec_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.rf_data_out = rf[bus.rf_readnum];
    always @(posedge clk) begin
        if (tb_ld)             rf[tb_addr] <= tb_data;
        else if (bus.rf_write) rf[bus.rf_writenum] <= bus.rf_data_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic load_reg(input logic [2:0] a, input logic [15:0] d);
        tb_ld = 1'b1; tb_addr = a; tb_data = d;
        tick();
        tb_ld = 1'b0;
    endtask

    // Issues one request and follows it to the cycle after write-back (cycle 5).
    task automatic run_op(input logic [1:0] op, input logic [1:0] sh,
                          input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                          input logic wb, output int dcyc, output bit wrote,
                          output logic [2:0] rd_a, output logic [2:0] rd_b, output int acc);
        bus.req_op = op; bus.req_shift = sh; bus.req_rn = rn;
        bus.req_rm = rm; bus.req_rd = rd; bus.req_wb = wb;
        bus.req_valid = 1'b1;
        acc = cyc;
        tick();
        bus.req_valid = 1'b0;
        dcyc = -1; wrote = 1'b0; rd_a = '0; rd_b = '0;
        for (int n = 1; n <= 12; n++) begin
            if (n == 1) rd_a = bus.rf_readnum;
            if (n == 2) rd_b = bus.rf_readnum;
            if (bus.rf_write) wrote = 1'b1;
            if (bus.done) begin
                dcyc = n;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b1;
        tick(); tick();
        chk("reset_ready",  32'(bus.req_ready), 32'd1);
        chk("reset_done",   32'(bus.done),      32'd0);
        chk("reset_write",  32'(bus.rf_write),  32'd0);
        chk("reset_result", 32'(bus.result),    32'd0);
        chk("reset_status", 32'(bus.status),    32'd0);
        chk("reset_rdnum",  32'(bus.rf_readnum), 32'd0);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        tick();
        chk("reset_no_accept", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic test_add();
        int dc; int acc; bit wr; logic [2:0] ra, rb;
        load_reg(3'd1, 16'd5); load_reg(3'd2, 16'd3); load_reg(3'd3, 16'hFFFF);
        run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd3, 1'b1, dc, wr, ra, rb, acc);
        chk("add_done_cycle", 32'(dc), 32'd4);
        chk("add_readnum_a",  32'(ra), 32'd1);
        chk("add_readnum_b",  32'(rb), 32'd2);
        chk("add_r3",         32'(rf[3]), 32'h0008);
        chk("add_result",     32'(bus.result), 32'h0008);
        chk("add_status",     32'(bus.status), 32'b000);
        chk("add_ready_after", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic test_overflow();
        int dc; int acc; bit wr; logic [2:0] ra, rb;
        load_reg(3'd1, 16'h7FFF); load_reg(3'd2, 16'h0001);
        run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd4, 1'b1, dc, wr, ra, rb, acc);
        chk("ovf_r4",     32'(rf[4]), 32'h8000);
        chk("ovf_status", 32'(bus.status), 32'b011);
    endtask

    task automatic test_compare();
        int dc; int acc; bit wr; logic [2:0] ra, rb;
        logic [15:0] snap [8];
        int diffs;
        load_reg(3'd1, 16'h1234);
        for (int i = 0; i < 8; i++) snap[i] = rf[i];
        run_op(2'b01, 2'b00, 3'd1, 3'd1, 3'd1, 1'b0, dc, wr, ra, rb, acc);
        chk("cmp_status",   32'(bus.status), 32'b100);
        chk("cmp_no_write", 32'(wr), 32'd0);
        chk("cmp_done",     32'(dc), 32'd4);
        diffs = 0;
        for (int i = 0; i < 8; i++) if (rf[i] !== snap[i]) diffs++;
        chk("cmp_rf_unchanged", 32'(diffs), 32'd0);
    endtask

    task automatic test_mvn_asr();
        int dc; int acc; bit wr; logic [2:0] ra, rb;
        load_reg(3'd2, 16'h8000);
        run_op(2'b11, 2'b11, 3'd0, 3'd2, 3'd5, 1'b1, dc, wr, ra, rb, acc);
        chk("mvn_r5",     32'(rf[5]), 32'h3FFF);
        chk("mvn_status", 32'(bus.status), 32'b000);
    endtask

    // Extra ALU/shift vectors: {op, shift, A, B, expected value, expected status}.
    task automatic test_alu_vectors();
        logic [1:0]  ops [3] = '{2'b10, 2'b01, 2'b01};
        logic [1:0]  shs [3] = '{2'b01, 2'b10, 2'b00};
        logic [15:0] av  [3] = '{16'h00F0, 16'h0005, 16'h8000};
        logic [15:0] bv  [3] = '{16'h0018, 16'h0014, 16'h0001};
        logic [15:0] ev  [3] = '{16'h0030, 16'hFFFB, 16'h7FFF};
        logic [2:0]  es  [3] = '{3'b000, 3'b010, 3'b001};
        int dc; int acc; bit wr; logic [2:0] ra, rb;
        for (int k = 0; k < 3; k++) begin
            load_reg(3'd1, av[k]); load_reg(3'd2, bv[k]);
            run_op(ops[k], shs[k], 3'd1, 3'd2, 3'd7, 1'b1, dc, wr, ra, rb, acc);
            chk($sformatf("vec%0d_r7", k),     32'(rf[7]), 32'(ev[k]));
            chk($sformatf("vec%0d_status", k), 32'(bus.status), 32'(es[k]));
        end
    endtask

    task automatic test_reset_in_wb();
        load_reg(3'd1, 16'd5); load_reg(3'd2, 16'd3); load_reg(3'd6, 16'hAAAA);
        bus.req_op = 2'b00; bus.req_shift = 2'b00; bus.req_rn = 3'd1;
        bus.req_rm = 3'd2; bus.req_rd = 3'd6; bus.req_wb = 1'b1;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick(); tick(); tick();
        chk("wbrst_done_before", 32'(bus.done), 32'd1);
        reset = 1'b1;
        #1;
        chk("wbrst_done_gated",  32'(bus.done),     32'd0);
        chk("wbrst_write_gated", 32'(bus.rf_write), 32'd0);
        tick();
        reset = 1'b0;
        chk("wbrst_r6",     32'(rf[6]), 32'hAAAA);
        chk("wbrst_ready",  32'(bus.req_ready), 32'd1);
        chk("wbrst_result", 32'(bus.result), 32'd0);
        tick();
        chk("wbrst_r6_late", 32'(rf[6]), 32'hAAAA);
    endtask

    task automatic test_back_to_back();
        int dc1, dc2, acc1, acc2; bit wr; logic [2:0] ra, rb;
        load_reg(3'd1, 16'd2); load_reg(3'd2, 16'd10);
        run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd1, 1'b1, dc1, wr, ra, rb, acc1);
        run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd7, 1'b1, dc2, wr, ra, rb, acc2);
        chk("b2b_r1",       32'(rf[1]), 32'd12);
        chk("b2b_r7",       32'(rf[7]), 32'd22);
        chk("b2b_interval", 32'(acc2 - acc1), 32'd5);
        chk("b2b_done2",    32'(dc2), 32'd4);
    endtask

    initial begin
        tb_ld = 1'b0; tb_addr = '0; tb_data = '0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_shift = '0;
        bus.req_rn = '0; bus.req_rm = '0; bus.req_rd = '0; bus.req_wb = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        test_reset();
        test_add();
        test_overflow();
        test_compare();
        test_mvn_asr();
        test_alu_vectors();
        test_reset_in_wb();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
